seq_magnitude_comparator: RTL and testbench

Parametrised, bit-serial, MSB-first magnitude comparator. It is the sequential successor of the team's 3-bit combinational A_greater_B / A_equal_B comparator.
- Generalised to WIDTH bits, with signed and unsigned modes.
- Adds an A_less_B output and a start/busy/done handshake.
- Sits beside datapath units that can spend WIDTH cycles on one compare in exchange for a small footprint.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/seq_magnitude_comparator_if.sv | 24 ++
 rtl/cmp_bit_step.sv | 25 ++
 rtl/seq_magnitude_comparator.sv | 96 +++++++++
 tb/tb_seq_magnitude_comparator.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UNDEC = 2'b00,
        GT    = 2'b01,
        LT    = 2'b10
    } dec_t;

    localparam logic CMP_EQ_RESET = 1'b1;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle between a client and the bit-serial comparator.
interface seq_magnitude_comparator_if #(parameter int WIDTH = 8);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_greater_B;
    logic             A_equal_B;
    logic             A_less_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_greater_B, A_equal_B, A_less_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_greater_B, A_equal_B, A_less_B
    );

endinterface

// File: rtl/cmp_bit_step.sv
// One MSB-first comparison step: refines the running decision with one bit pair.
module cmp_bit_step
    import cmp_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic signed_mode,
    input  dec_t dec_in,
    output dec_t dec_out
);

    always_comb begin
        dec_out = dec_in;
        if (dec_in == UNDEC && a_bit != b_bit) begin
            // A set sign bit marks the negative, hence smaller, operand.
            if (signed_mode && is_msb) begin
                dec_out = a_bit ? LT : GT;
            end else begin
                dec_out = a_bit ? GT : LT;
            end
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial MSB-first signed/unsigned magnitude comparator with start/busy/done.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    seq_magnitude_comparator_if.slave  cmp
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             mode_q;
    logic [CNT_W-1:0] idx_q;
    dec_t             dec_q, dec_step;
    logic             gt_q, eq_q, lt_q;
    logic             last_bit, is_msb, finish_step;

    assign last_bit = (idx_q == '0);
    assign is_msb   = (idx_q == CNT_W'(WIDTH-1));

    cmp_bit_step u_step (
        .a_bit       (a_q[idx_q]),
        .b_bit       (b_q[idx_q]),
        .is_msb      (is_msb),
        .signed_mode (mode_q),
        .dec_in      (dec_q),
        .dec_out     (dec_step)
    );

`ifdef CMP_EARLY_EXIT_EN
    assign finish_step = last_bit || (dec_step != UNDEC);
`else
    assign finish_step = last_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmp.start) state_d = SHIFT;
            SHIFT:   if (finish_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
            dec_q  <= UNDEC;
            gt_q   <= 1'b0;
            eq_q   <= CMP_EQ_RESET;
            lt_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && cmp.start) begin
                a_q    <= cmp.A;
                b_q    <= cmp.B;
                mode_q <= cmp.signed_mode;
                idx_q  <= CNT_W'(WIDTH-1);
                dec_q  <= UNDEC;
            end
            if (state_q == SHIFT) begin
                dec_q <= dec_step;
                idx_q <= idx_q - 1'b1;
                // Results change only here, so they hold between done pulses.
                if (finish_step) begin
                    gt_q <= (dec_step == GT);
                    lt_q <= (dec_step == LT);
                    eq_q <= (dec_step == UNDEC);
                end
            end
        end
    end

    assign cmp.busy        = (state_q != IDLE);
    assign cmp.done        = (state_q == DONE);
    assign cmp.A_greater_B = gt_q;
    assign cmp.A_equal_B   = eq_q;
    assign cmp.A_less_B    = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator with directed vectors (WIDTH=8).
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 8;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [2:0] res;
        int         lat;
        int         lat_ee;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[10];

    seq_magnitude_comparator_if #(.WIDTH(WIDTH)) cif ();

    seq_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input vec_t v);
`ifdef CMP_EARLY_EXIT_EN
        return v.lat_ee;
`else
        return v.lat;
`endif
    endfunction

    function automatic logic [2:0] res_now();
        return {cif.A_greater_B, cif.A_equal_B, cif.A_less_B};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot", 32'($countones(res_now())), 32'd1);
            if (cif.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(res_now()), 32'(e.res));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input vec_t v);
        @(negedge clk);
        cif.A           = v.a;
        cif.B           = v.b;
        cif.signed_mode = v.m;
        cif.start       = 1'b1;
        sb.push_back('{v.res, cyc + 1 + lat_of(v)});
        @(negedge clk);
        cif.start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{8'h5A, 8'h5A, 1'b0, R_EQ, 8, 8};
        vecs[1] = '{8'h80, 8'h01, 1'b1, R_LT, 8, 1};
        vecs[2] = '{8'h80, 8'h01, 1'b0, R_GT, 8, 1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b1, R_GT, 8, 1};
        vecs[4] = '{8'h03, 8'h04, 1'b0, R_LT, 8, 6};
        vecs[5] = '{8'h80, 8'h00, 1'b0, R_GT, 8, 1};
        vecs[6] = '{8'h80, 8'h00, 1'b1, R_LT, 8, 1};
        vecs[7] = '{8'hFE, 8'hFF, 1'b1, R_LT, 8, 8};
        vecs[8] = '{8'h00, 8'hFF, 1'b1, R_GT, 8, 1};
        vecs[9] = '{8'h12, 8'h10, 1'b0, R_GT, 8, 7};

        rst_n           = 1'b0;
        cif.start       = 1'b0;
        cif.signed_mode = 1'b0;
        cif.A           = '0;
        cif.B           = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(cif.busy), 32'd0);
        check("rst_done", 32'(cif.done), 32'd0);
        check("rst_result", 32'(res_now()), 32'(R_EQ));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(cif.busy), 32'd0);
        check("idle_result", 32'(res_now()), 32'(R_EQ));

        for (int i = 0; i < 10; i++) issue(vecs[i]);

        // Starts at edges 3 and 5 with different operands must be ignored.
        @(negedge clk);
        cif.A = 8'h03; cif.B = 8'h04; cif.signed_mode = 1'b0; cif.start = 1'b1;
        sb.push_back('{R_LT, cyc + 1 + lat_of(vecs[4])});
        @(negedge clk);
        cif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_mid", 32'(cif.busy), 32'd1);
        cif.A = 8'hFF; cif.B = 8'h00; cif.signed_mode = 1'b1; cif.start = 1'b1;
        @(negedge clk);
        cif.start = 1'b0;
        @(negedge clk);
        cif.start = 1'b1;
        @(negedge clk);
        cif.start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        // Continuous start: two compares back to back, operands swapped mid-flight.
        @(negedge clk);
        cif.A = vecs[1].a; cif.B = vecs[1].b; cif.signed_mode = vecs[1].m; cif.start = 1'b1;
        c0 = cyc + 1;
        sb.push_back('{vecs[1].res, c0 + lat_of(vecs[1])});
        @(negedge clk);
        cif.A = vecs[0].a; cif.B = vecs[0].b; cif.signed_mode = vecs[0].m;
        sb.push_back('{vecs[0].res, c0 + lat_of(vecs[1]) + 2 + lat_of(vecs[0])});
        repeat (lat_of(vecs[1]) + 2) @(negedge clk);
        cif.start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        // Make the held result non-equal, then abort a compare at edge 4.
        issue(vecs[9]);
        @(negedge clk);
        cif.A = 8'h00; cif.B = 8'h01; cif.signed_mode = 1'b0; cif.start = 1'b1;
        @(negedge clk);
        cif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_result", 32'(res_now()), 32'(R_GT));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(cif.busy), 32'd0);
        check("abort_done", 32'(cif.done), 32'd0);
        check("abort_result", 32'(res_now()), 32'(R_EQ));
        repeat (2) @(negedge clk);
        check("abort_hold_done", 32'(cif.done), 32'd0);
        rst_n = 1'b1;
        issue(vecs[3]);
        issue(vecs[7]);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
